// File: rtl/cmul_rr_sched_if.sv
// -----------------------------------------------------------------------------
// cmul_rr_sched_if
// Bundle of the requester, datapath and output-FIFO signals of cmul_rr_sched.
//   req_valid/req_ready : per-requester operand handshake (NREQ bits each)
//   req_ra/req_rb       : requester i operands at [i*W +: W]
//   dp_ra/dp_rb         : operands sent to the shared rotate datapath
//   dp_real/dp_image    : datapath results (fixed latency)
//   out_valid/out_ready : output FIFO head handshake
//   out_id/out_real/out_image : head entry contents
// Modports: slave = scheduler side, master = environment side.
// -----------------------------------------------------------------------------
interface cmul_rr_sched_if #(
    parameter int N    = 4,
    parameter int NREQ = 4
);
    localparam int W   = 2 ** N;
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_ra;
    logic [NREQ*W-1:0] req_rb;
    logic [W-1:0]      dp_ra;
    logic [W-1:0]      dp_rb;
    logic [W-1:0]      dp_real;
    logic [W-1:0]      dp_image;
    logic              out_valid;
    logic              out_ready;
    logic [IDW-1:0]    out_id;
    logic [W-1:0]      out_real;
    logic [W-1:0]      out_image;

    modport slave (
        input  req_valid, req_ra, req_rb, dp_real, dp_image, out_ready,
        output req_ready, dp_ra, dp_rb, out_valid, out_id, out_real, out_image
    );

    modport master (
        output req_valid, req_ra, req_rb, dp_real, dp_image, out_ready,
        input  req_ready, dp_ra, dp_rb, out_valid, out_id, out_real, out_image
    );
endinterface

// File: rtl/cmul_rr_sched.sv
// -----------------------------------------------------------------------------
// cmul_rr_sched
// Round-robin scheduler sharing one fixed-latency, non-stallable complex-rotate
// datapath between NREQ requesters. Each issue is tagged with its requester ID
// through a LAT-deep tag pipeline; results land in a first-word-fall-through
// output FIFO protected by credits so downstream backpressure never drops data.
//
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : cmul_rr_sched_if.slave (requester, datapath and output signals)
//   stat_issued, stat_stall : saturating 16-bit counters, present only when
//                             CMUL_SCHED_STATS_EN is defined
//
// Optional feature macro: CMUL_SCHED_STATS_EN
// -----------------------------------------------------------------------------
module cmul_rr_sched #(
    parameter int N     = 4,
    parameter int NREQ  = 4,
    parameter int LAT   = 3,
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    cmul_rr_sched_if.slave     bus
`ifdef CMUL_SCHED_STATS_EN
    ,
    output logic [15:0]        stat_issued,
    output logic [15:0]        stat_stall
`endif
);
    localparam int W   = 2 ** N;
    localparam int IDW = $clog2(NREQ);
    localparam int CW  = $clog2(DEPTH + 1);
    localparam int AW  = $clog2(DEPTH);

    // Handshake: a transfer on requester i happens at a rising edge where
    // req_valid[i] and req_ready[i] are both 1; a pop happens where out_valid
    // and out_ready are both 1. req_ready never looks at out_ready.

    logic [IDW-1:0] last_grant_q;
    logic [CW-1:0]  credit_q, credit_d;
    logic           grant_vld;
    logic [IDW-1:0] grant_id;
    logic [IDW-1:0] arb_idx;
    logic           issue;
    logic           pop;

    // Search starts one past the last winner and wraps modulo NREQ.
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = '0;
        arb_idx   = '0;
        for (int off = 1; off <= NREQ; off++) begin
            arb_idx = IDW'((int'(last_grant_q) + off) % NREQ);
            if (!grant_vld && (credit_q != '0) && bus.req_valid[arb_idx]) begin
                grant_vld = 1'b1;
                grant_id  = arb_idx;
            end
        end
    end

    assign issue = grant_vld;

    always_comb begin
        bus.req_ready = '0;
        if (grant_vld) bus.req_ready[grant_id] = 1'b1;
    end

    assign bus.dp_ra = grant_vld ? bus.req_ra[grant_id*W +: W] : '0;
    assign bus.dp_rb = grant_vld ? bus.req_rb[grant_id*W +: W] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) last_grant_q <= IDW'(NREQ - 1);
        else if (issue) last_grant_q <= grant_id;
    end

    // Credits cover in-flight operations plus FIFO occupancy.
    always_comb begin
        credit_d = credit_q;
        if (issue && !pop) credit_d = credit_q - CW'(1);
        else if (!issue && pop) credit_d = credit_q + CW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) credit_q <= CW'(DEPTH);
        else credit_q <= credit_d;
    end

    // Tag pipeline tracking the datapath; clearing it on reset drops
    // whatever the datapath still has in flight.
    logic [LAT-1:0] tag_vld_q;
    logic [IDW-1:0] tag_id_q [LAT];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_vld_q <= '0;
            for (int i = 0; i < LAT; i++) tag_id_q[i] <= '0;
        end else begin
            tag_vld_q[0] <= issue;
            tag_id_q[0]  <= grant_id;
            for (int i = 1; i < LAT; i++) begin
                tag_vld_q[i] <= tag_vld_q[i-1];
                tag_id_q[i]  <= tag_id_q[i-1];
            end
        end
    end

    // Output FIFO (first-word-fall-through).
    logic [IDW-1:0] fid_mem [DEPTH];
    logic [W-1:0]   fre_mem [DEPTH];
    logic [W-1:0]   fim_mem [DEPTH];
    logic [AW:0]    wr_ptr_q, rd_ptr_q;
    logic           wr_en;
    logic           fifo_empty;
    logic [IDW-1:0] hold_id_q;
    logic [W-1:0]   hold_re_q, hold_im_q;

    assign wr_en      = tag_vld_q[LAT-1];
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign pop        = !fifo_empty && bus.out_ready;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            fid_mem[wr_ptr_q[AW-1:0]] <= tag_id_q[LAT-1];
            fre_mem[wr_ptr_q[AW-1:0]] <= bus.dp_real;
            fim_mem[wr_ptr_q[AW-1:0]] <= bus.dp_image;
        end
    end

    // The hold registers keep the most recently popped head so the outputs
    // stay stable while the FIFO is empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            hold_id_q <= '0;
            hold_re_q <= '0;
            hold_im_q <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            if (pop) begin
                rd_ptr_q  <= rd_ptr_q + (AW+1)'(1);
                hold_id_q <= fid_mem[rd_ptr_q[AW-1:0]];
                hold_re_q <= fre_mem[rd_ptr_q[AW-1:0]];
                hold_im_q <= fim_mem[rd_ptr_q[AW-1:0]];
            end
        end
    end

    assign bus.out_valid = !fifo_empty;
    assign bus.out_id    = fifo_empty ? hold_id_q : fid_mem[rd_ptr_q[AW-1:0]];
    assign bus.out_real  = fifo_empty ? hold_re_q : fre_mem[rd_ptr_q[AW-1:0]];
    assign bus.out_image = fifo_empty ? hold_im_q : fim_mem[rd_ptr_q[AW-1:0]];

`ifdef CMUL_SCHED_STATS_EN
    logic [15:0] stat_issued_q, stat_stall_q;
    logic        stall;

    assign stall = (|bus.req_valid) && (credit_q == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_issued_q <= '0;
            stat_stall_q  <= '0;
        end else begin
            if (issue && stat_issued_q != 16'hFFFF) stat_issued_q <= stat_issued_q + 16'd1;
            if (stall && stat_stall_q != 16'hFFFF) stat_stall_q <= stat_stall_q + 16'd1;
        end
    end

    assign stat_issued = stat_issued_q;
    assign stat_stall  = stat_stall_q;
`endif
endmodule
